// File: rtl/fpu_norm_pkg.sv
// Shared constants for the arch3 FP add/subtract normalizer: FSM state
// encoding and the exponent limits used for saturation.
package fpu_norm_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CHECK = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Wide forms; each user slices them down to its own exponent width.
    localparam logic [63:0] EXP_MAX      = {64{1'b1}};
    localparam logic [63:0] EXP_MIN_NORM = 64'd1;

endpackage

// File: rtl/mant_norm_seq.sv
// Sequential significand normalizer: one right shift on carry-out or one left
// shift per cycle until the hidden bit is set, with exponent saturation.
module mant_norm_seq #(
    parameter int W  = 26,
    parameter int EW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         mant_in,
    input  logic [EW-1:0]        exp_in,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         mant_out,
    output logic [EW-1:0]        exp_out,
    output logic [$clog2(W)-1:0] shift_cnt,
    output logic                 zero,
    output logic                 overflow,
    output logic                 underflow
);
    import fpu_norm_pkg::*;

    localparam int CW = $clog2(W);
    localparam logic [EW-1:0] EXP_ALL1 = EXP_MAX[EW-1:0];
    localparam logic [EW-1:0] EXP_ONE  = EXP_MIN_NORM[EW-1:0];
    // An increment from this value or above would reach all-ones or wrap.
    localparam logic [EW-1:0] EXP_OVF  = EXP_ALL1 - EXP_ONE;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  mant_q, mant_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          stop_s;

    // Any CHECK rule other than the plain left shift ends the operation.
    always_comb begin
        stop_s = (mant_q == {W{1'b0}}) || mant_q[W-1] || mant_q[W-2]
                 || (exp_q <= EXP_ONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (stop_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values: one normalization rule per CHECK cycle.
    always_comb begin
        mant_d = mant_q;
        exp_d  = exp_q;
        cnt_d  = cnt_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mant_d = mant_in;
                    exp_d  = exp_in;
                    cnt_d  = {CW{1'b0}};
                    zero_d = 1'b0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (stop_s) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
                if (mant_q == {W{1'b0}}) begin
                    zero_d = 1'b1;
                    exp_d  = {EW{1'b0}};
                end else if (mant_q[W-1]) begin
                    if (exp_q >= EXP_OVF) begin
                        ovf_d  = 1'b1;
                        exp_d  = EXP_ALL1;
                        mant_d = {W{1'b0}};
                    end else begin
                        // The bit shifted out is kept as sticky in bit 0.
                        mant_d = {1'b0, mant_q[W-1:2], mant_q[1] | mant_q[0]};
                        exp_d  = exp_q + EXP_ONE;
                    end
                end else if (mant_q[W-2]) begin
                    mant_d = mant_q;
                end else if (exp_q <= EXP_ONE) begin
                    unf_d = 1'b1;
                    exp_d = EXP_ONE;
                end else begin
                    mant_d = {mant_q[W-2:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Working registers double as the held result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mant_q <= {W{1'b0}};
            exp_q  <= {EW{1'b0}};
            cnt_q  <= {CW{1'b0}};
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mant_q <= mant_d;
            exp_q  <= exp_d;
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mant_out  = mant_q;
    assign exp_out   = exp_q;
    assign shift_cnt = cnt_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_mant_norm_seq.sv
// Randomized scoreboard bench for mant_norm_seq: a closed-form reference model
// predicts each result, and a monitor compares on every done pulse.
module tb_mant_norm_seq;
    localparam int W    = 26;
    localparam int EW   = 8;
    localparam int CW   = $clog2(W);
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  mant_in = '0;
    logic [EW-1:0] exp_in = '0;
    logic          busy, done, zero, overflow, underflow;
    logic [W-1:0]  mant_out;
    logic [EW-1:0] exp_out;
    logic [CW-1:0] shift_cnt;

    mant_norm_seq #(.W(W), .EW(EW)) dut (
        .clk(clk), .rst(rst), .start(start), .mant_in(mant_in), .exp_in(exp_in),
        .busy(busy), .done(done), .mant_out(mant_out), .exp_out(exp_out),
        .shift_cnt(shift_cnt), .zero(zero), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  mant;
        logic [EW-1:0] ex;
        int            cnt;
        bit            zero;
        bit            ovf;
        bit            unf;
        int            lat;
        int            issued;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: leading-one position gives the needed shift count directly.
    function automatic exp_t model(input logic [W-1:0] m, input logic [EW-1:0] e);
        exp_t   r;
        longint mv;
        int     ev, p, k, s;
        mv = longint'(m);
        ev = int'(e);
        r.mant = m; r.ex = e; r.cnt = 0; r.zero = 1'b0; r.ovf = 1'b0; r.unf = 1'b0;
        r.lat = 2; r.issued = 0;
        if (mv == 0) begin
            r.zero = 1'b1;
            r.ex   = '0;
        end else if (mv >= (longint'(1) << (W - 1))) begin
            if (ev + 1 >= EMAX) begin
                r.ovf  = 1'b1;
                r.ex   = EW'(EMAX);
                r.mant = '0;
            end else begin
                mv     = (mv >> 1) | (mv & longint'(1));
                r.mant = W'(mv);
                r.ex   = EW'(ev + 1);
            end
        end else begin
            p = 0;
            for (int i = 0; i < W; i++) if (mv[i]) p = i;
            k = (W - 2) - p;
            s = (ev > 1) ? ((k < ev - 1) ? k : ev - 1) : 0;
            mv     = mv << s;
            r.mant = W'(mv);
            r.ex   = EW'(ev - s);
            r.cnt  = s;
            r.lat  = 2 + s;
            if (s < k) begin
                r.unf = 1'b1;
                r.ex  = EW'(1);
            end
        end
        return r;
    endfunction

    // Called at a falling edge; waits for IDLE, then presents one start pulse.
    task automatic issue(input logic [W-1:0] m, input logic [EW-1:0] e);
        int   n;
        exp_t t;
        n = 0;
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles", busy, done, n);
        end
        t = model(m, e);
        t.issued = cyc;
        sb_q.push_back(t);
        mant_in = m;
        exp_in  = e;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t t;
        if (rst && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: mant=0x%0h exp=0x%0h, expected no result", mant_out, exp_out);
            end else begin
                t = sb_q.pop_front();
                chk("mant_out",  64'(mant_out),  64'(t.mant));
                chk("exp_out",   64'(exp_out),   64'(t.ex));
                chk("shift_cnt", 64'(shift_cnt), 64'(t.cnt));
                chk("zero",      64'(zero),      64'(t.zero));
                chk("overflow",  64'(overflow),  64'(t.ovf));
                chk("underflow", 64'(underflow), 64'(t.unf));
                chk("latency",   64'(cyc - t.issued), 64'(t.lat));
                chk("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  64'(busy),      64'(0));
        chk({tag, "_done"},  64'(done),      64'(0));
        chk({tag, "_mant"},  64'(mant_out),  64'(0));
        chk({tag, "_exp"},   64'(exp_out),   64'(0));
        chk({tag, "_cnt"},   64'(shift_cnt), 64'(0));
        chk({tag, "_flags"}, 64'({zero, overflow, underflow}), 64'(0));
    endtask

    initial begin
        int            d0, n, cls;
        logic [63:0]   rnd;
        logic [W-1:0]  m;
        logic [EW-1:0] e;

        #2;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        issue(26'h1000000, 8'h80);
        issue(26'h3000001, 8'h80);
        issue(26'h0000000, 8'h55);
        issue(26'h2000000, 8'hFE);
        issue(26'h0000010, 8'h02);

        // Left-shift case with busy profile and a start raised mid-operation.
        issue(26'h0200000, 8'h80);
        d0 = done_cnt;
        chk("busy_c1", 64'(busy), 64'(1));
        mant_in = 26'h1000000;
        exp_in  = 8'h10;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chk("busy_c2", 64'(busy), 64'(1));
        @(negedge clk);
        chk("busy_c3", 64'(busy), 64'(1));
        @(negedge clk);
        chk("busy_c4", 64'(busy), 64'(1));
        chk("done_c4", 64'(done), 64'(0));
        @(negedge clk);
        chk("done_c5", 64'(done), 64'(1));
        repeat (4) @(negedge clk);
        chk("single_done", 64'(done_cnt - d0), 64'(1));

        // Asynchronous abort in the middle of the left-shift case.
        issue(26'h0200000, 8'h80);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("abort");
        sb_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_done_after_abort", 64'(done_cnt - d0), 64'(0));
        issue(26'h0400000, 8'h40);

        for (int i = 0; i < 300; i++) begin
            rnd = {$urandom(), $urandom()};
            cls = int'($urandom_range(0, 5));
            case (cls)
                0:       m = '0;
                1:       m = {1'b1, rnd[W-2:0]};
                2:       m = {2'b01, rnd[W-3:0]};
                default: m = rnd[W-1:0] >> $urandom_range(0, W - 1);
            endcase
            case ($urandom_range(0, 3))
                0:       e = EW'($urandom_range(0, 4));
                1:       e = EW'($urandom_range(250, 255));
                default: e = EW'($urandom_range(0, 255));
            endcase
            issue(m, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
